// File: rtl/input_debounce.sv
`timescale 1ns / 1ps
// input_debounce
//   Synchronises a raw asynchronous pin into clk, requires a new level to persist for DEBOUNCE
//   consecutive cycles before accepting it, and presents a clean level with single-cycle
//   rise/fall strobes. Rejected transitions are counted in a saturating diagnostic counter.
//
// Ports
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   din          in   raw asynchronous pin
//   glitch_clr   in   synchronous clear of glitch_count (wins over a same-cycle glitch)
//   dout         out  debounced level (registered)
//   rise         out  one-cycle strobe in the cycle dout shows 0->1
//   fall         out  one-cycle strobe in the cycle dout shows 1->0
//   glitch_count out  saturating count of rejected transitions
module input_debounce #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 16,
    parameter bit          INVERT      = 1'b0,
    parameter bit          RESET_LEVEL = 1'b0,
    parameter int unsigned GLITCH_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                din,
    input  logic                glitch_clr,
    output logic                dout,
    output logic                rise,
    output logic                fall,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam int unsigned                CntW      = $clog2(DEBOUNCE + 1);
    localparam logic [CntW-1:0]            CntLast   = CntW'(DEBOUNCE - 1);
    // The synchroniser holds the raw-pin polarity, so it resets to the pre-inversion level.
    localparam logic [SYNC_STAGES-1:0]     SyncReset = {SYNC_STAGES{RESET_LEVEL ^ INVERT}};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [GLITCH_W-1:0]    glitch_q, glitch_d;

    logic s;
    logic accept;
    logic glitch;

    assign s = sync_q[SYNC_STAGES-1] ^ INVERT;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], din};
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        accept   = 1'b0;
        glitch   = 1'b0;
        glitch_d = glitch_q;

        if (cnt_q == '0) begin
            // Stable: a differing level starts qualification (or is taken at once for DEBOUNCE=1).
            if (s != dout_q) begin
                if (DEBOUNCE == 1) begin
                    accept = 1'b1;
                end else begin
                    cnt_d = CntW'(1);
                end
            end
        end else if (s == dout_q) begin
            // Level fell back before qualifying: reject and count it.
            glitch = 1'b1;
            cnt_d  = '0;
        end else if (cnt_q == CntLast) begin
            accept = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (accept) begin
            dout_d = s;
        end
        rise_d = accept & s;
        fall_d = accept & ~s;

        if (glitch_clr) begin
            glitch_d = '0;
        end else if (glitch && (glitch_q != '1)) begin
            glitch_d = glitch_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= SyncReset;
            cnt_q    <= '0;
            dout_q   <= RESET_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign dout         = dout_q;
    assign rise         = rise_q;
    assign fall         = fall_q;
    assign glitch_count = glitch_q;

endmodule

// File: tb/tb_input_debounce.sv
`timescale 1ns / 1ps
// Bench for input_debounce: three instances (defaults, GLITCH_W=2, inverted fast variant) share
// one stimulus stream built from level segments. Expected strobes are derived per segment from
// its length and pushed to per-instance queues; a negedge monitor pops them as strobes appear.
module tb_input_debounce;

    logic clk = 1'b0;
    logic rst_n;
    logic din;
    logic glitch_clr;

    always #5 clk = ~clk;

    logic       d0, r0, f0, d1, r1, f1, d2, r2, f2;
    logic [7:0] gc0, gc2;
    logic [1:0] gc1;

    logic       dout_w [3];
    logic       rise_w [3];
    logic       fall_w [3];
    logic [7:0] gc_w   [3];

    always_comb begin
        dout_w[0] = d0; rise_w[0] = r0; fall_w[0] = f0; gc_w[0] = gc0;
        dout_w[1] = d1; rise_w[1] = r1; fall_w[1] = f1; gc_w[1] = {6'b0, gc1};
        dout_w[2] = d2; rise_w[2] = r2; fall_w[2] = f2; gc_w[2] = gc2;
    end

    input_debounce u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .glitch_clr(glitch_clr),
        .dout(d0), .rise(r0), .fall(f0), .glitch_count(gc0)
    );

    input_debounce #(.GLITCH_W(2)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .din(din), .glitch_clr(glitch_clr),
        .dout(d1), .rise(r1), .fall(f1), .glitch_count(gc1)
    );

    input_debounce #(.SYNC_STAGES(3), .DEBOUNCE(1), .INVERT(1'b1)) u_dut_inv (
        .clk(clk), .rst_n(rst_n), .din(din), .glitch_clr(glitch_clr),
        .dout(d2), .rise(r2), .fall(f2), .glitch_count(gc2)
    );

    localparam int S_P   [3] = '{2, 2, 3};
    localparam int D_P   [3] = '{16, 16, 1};
    localparam int INV_P [3] = '{0, 0, 1};
    localparam int GMAX  [3] = '{255, 3, 255};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int exp_q  [3][$];   // entries: edge*2 + new level
    int dout_m [3];
    int gcnt_m [3];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One level segment of din, lasting len edges; optional glitch_clr pulse clr_at edges in.
    task automatic seg(input logic lvl, input int len, input int clr_at);
        int start;
        int s_lvl;
        din   = lvl;
        start = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            s_lvl = int'(lvl) ^ INV_P[i];
            if (s_lvl != dout_m[i]) begin
                if (len >= D_P[i]) begin
                    exp_q[i].push_back((start + S_P[i] + D_P[i] - 1) * 2 + s_lvl);
                    dout_m[i] = s_lvl;
                end else if (gcnt_m[i] < GMAX[i]) begin
                    gcnt_m[i]++;
                end
            end
            if (clr_at >= 0) gcnt_m[i] = 0;
        end
        if (clr_at >= 0) begin
            repeat (clr_at) @(posedge clk);
            #1 glitch_clr = 1'b1;
            @(posedge clk);
            #1 glitch_clr = 1'b0;
            repeat (len - clr_at - 1) @(posedge clk);
            #1;
        end else begin
            repeat (len) @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int hold);
        int redge;
        rst_n = 1'b0;
        redge = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            for (int k = exp_q[i].size() - 1; k >= 0; k--) begin
                if ((exp_q[i][k] >>> 1) >= redge) exp_q[i].delete(k);
            end
            dout_m[i] = 0;
            gcnt_m[i] = 0;
        end
        repeat (hold) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_dout[%0d]", i), 32'(dout_w[i]), 0);
            chk($sformatf("reset_strobes[%0d]", i), {30'b0, rise_w[i], fall_w[i]}, 0);
            chk($sformatf("reset_glitch[%0d]", i), 32'(gc_w[i]), 0);
        end
        rst_n = 1'b1;
    endtask

    task automatic check_state(input string name);
        int due;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_dout[%0d]", name, i), 32'(dout_w[i]), 32'(dout_m[i]));
            chk($sformatf("%s_glitch[%0d]", name, i), 32'(gc_w[i]), 32'(gcnt_m[i]));
            due = 0;
            foreach (exp_q[i][k]) if ((exp_q[i][k] >>> 1) <= cyc) due++;
            chk($sformatf("%s_missed_strobes[%0d]", name, i), due, 0);
        end
    endtask

    // Monitor: every strobe must match the head of that instance's expectation queue.
    always @(negedge clk) begin
        int e;
        for (int i = 0; i < 3; i++) begin
            if (rise_w[i] === 1'b1 || fall_w[i] === 1'b1) begin
                chk($sformatf("strobe_excl[%0d]", i), 32'(rise_w[i] & fall_w[i]), 0);
                chk($sformatf("strobe_dout[%0d]", i), 32'(dout_w[i]), 32'(rise_w[i]));
                if (exp_q[i].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe[%0d]: got rise=%b fall=%b at edge %0d, required none",
                             i, rise_w[i], fall_w[i], cyc);
                end else begin
                    e = exp_q[i].pop_front();
                    n_tests++;
                    if (e != cyc * 2 + int'(rise_w[i])) begin
                        n_fail++;
                        $display("FAIL strobe[%0d]: got edge %0d rise=%b, required edge %0d rise=%0d",
                                 i, cyc, rise_w[i], e >>> 1, e & 1);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic lvl;
        int   len;
        din        = 1'b1;
        glitch_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dout_m[i] = 0;
            gcnt_m[i] = 0;
        end

        // Reset with din already high, then qualify from scratch after release.
        do_reset(3);
        seg(1'b1, 50, -1);
        seg(1'b0, 50, -1);
        check_state("clean_pulse");

        // Short pulses are rejected and counted; then cleared.
        seg(1'b1, 15, -1); seg(1'b0, 40, -1);
        seg(1'b1, 3, -1);  seg(1'b0, 40, -1);
        seg(1'b1, 1, -1);  seg(1'b0, 40, -1);
        check_state("glitches");
        seg(1'b0, 40, 0);
        check_state("glitch_clr");

        // Exactly DEBOUNCE accepted, DEBOUNCE-1 rejected.
        seg(1'b1, 16, -1); seg(1'b0, 40, -1);
        seg(1'b1, 15, -1); seg(1'b0, 40, -1);
        check_state("boundary");

        // Saturation of the narrow counter, then a clear landing on the glitch edge.
        repeat (6) begin
            seg(1'b1, 5, -1);
            seg(1'b0, 30, -1);
        end
        check_state("saturate");
        seg(1'b1, 5, -1);
        seg(1'b0, 40, 2);
        check_state("clr_vs_glitch");

        // Reset in the middle of qualification discards the pending edge.
        seg(1'b1, 8, -1);
        do_reset(2);
        seg(1'b1, 40, -1);
        seg(1'b0, 40, -1);
        check_state("reset_mid_qualify");

        // Random alternating segments, lengths biased around the qualification boundary.
        lvl = 1'b0;
        for (int n = 0; n < 60; n++) begin
            lvl = ~lvl;
            len = $urandom_range(1, 40);
            if ($urandom_range(0, 3) == 0) len = 15 + $urandom_range(0, 1);
            seg(lvl, len, -1);
        end
        seg(1'b1, 60, -1);
        seg(1'b0, 60, -1);
        check_state("random");

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("leftover_expected[%0d]", i), exp_q[i].size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/input_debounce.md
# input_debounce

Conditioning stage placed directly upstream of `oneshot` on every asynchronous digital input (switches, limit/home sensors, probe). It synchronises the raw pin into `clk`, rejects pulses shorter than a programmable qualification time, and presents a clean level plus single-cycle rise/fall strobes that drive `oneshot.din` or the register map. It also keeps a saturating count of rejected glitches for diagnostics.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth; legal range ≥ 2.
- `DEBOUNCE`, 16: consecutive `clk` cycles a new level must persist before acceptance; legal range ≥ 1.
- `INVERT`, 0: when 1, the pin is active-low and is inverted after synchronisation.
- `RESET_LEVEL`, 0: post-inversion level that `dout` and the synchroniser take during reset.
- `GLITCH_W`, 8: width of `glitch_count`.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous active-low reset, sampled on `clk` rising edge.
- `din`  in  1  raw asynchronous pin.
- `glitch_clr`  in  1  synchronous clear of `glitch_count`.
- `dout`  out  1  debounced level, registered.
- `rise`  out  1  one-cycle strobe, high in the cycle `dout` goes 0→1.
- `fall`  out  1  one-cycle strobe, high in the cycle `dout` goes 1→0.
- `glitch_count`  out  GLITCH_W  saturating count of rejected transitions.

## Operation
- **Synchroniser.** `SYNC_STAGES` flops in series. `s` = last stage XOR `INVERT`.
- **Counter.** `cnt` is `$clog2(DEBOUNCE+1)` bits wide. It counts consecutive cycles with `s != dout`.
- **STABLE** (`cnt == 0`):
  - If `s != dout` and `DEBOUNCE == 1`: `dout <= s` immediately and `cnt` stays 0.
  - Else if `s != dout`: `cnt <= 1` and enter QUALIFY.
- **QUALIFY** (`cnt != 0`):
  - If `s == dout`: this is a glitch. `cnt <= 0` and `glitch_count` increments, holding at all-ones.
  - Else if `cnt == DEBOUNCE-1`: accept. `dout <= s` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
- **Strobes.** `rise <= accept & s`; `fall <= accept & ~s`. The strobes are registered together with `dout`, so each strobe is high in exactly the cycle `dout` shows its new value.
- **Glitch clear.** `glitch_clr` sets `glitch_count` to 0. If a glitch occurs in the same cycle, the clear wins and the result is 0.
- **Reset.**
  - Values loaded: synchroniser flops = `RESET_LEVEL ^ INVERT`, `dout` = `RESET_LEVEL`, `rise` = `fall` = 0, `cnt` = 0, `glitch_count` = 0.
  - No strobe is ever produced by reset assertion or release.
  - Reset during QUALIFY discards the pending transition.
  - After release, a `din` already at the opposite level must qualify from scratch.

## Timing
- All outputs are registered; there is no combinational path from `din` or `glitch_clr` to any output.
- **Latency.** Let E0 be the first rising edge that samples a new `din` level. If `din` stays stable from then on, `dout`, `rise` and `fall` update on edge E(`SYNC_STAGES`+`DEBOUNCE`−1). Defaults: E17, i.e. 18 edges.
- **Shortest accepted pulse.** `din` held for `DEBOUNCE` cycles (as seen at `s`) is accepted; `DEBOUNCE`−1 cycles is rejected and counted as one glitch.
- **Strobe spacing.** Two accepted edges are at least `DEBOUNCE` cycles apart, so `rise` and `fall` are never high together.
- **Counter saturation.** `glitch_count` saturates at 2^`GLITCH_W`−1 and never wraps.

## Test plan
- **Reset.** Hold `rst_n`=0 for 3 cycles with `din`=1, `RESET_LEVEL`=0 → `dout`=0, `rise`=0, `fall`=0, `glitch_count`=0. Release with `din`=1 → `rise`=1 for exactly one cycle on edge 17 after release (defaults), and `dout` rises in the same cycle.
- **Clean pulse.** `din` 0→1 held 50 cycles, then 0 → `dout` rises on E17 with a 1-cycle `rise`. `dout` falls 50 cycles later with a 1-cycle `fall`. `glitch_count` stays 0.
- **Glitch rejection.** `din` pulses of 15, 3 and 1 cycles, separated by 40 idle cycles → `dout` stays 0, no strobes, `glitch_count`=3. Then pulse `glitch_clr` → `glitch_count`=0.
- **Boundary length.** `din` pulses of exactly 16 cycles and exactly 15 cycles → the first yields one `rise` and a later `fall`; the second yields none and increments `glitch_count` by 1.
- **Saturation and simultaneous clear.** With `GLITCH_W`=2, apply 6 glitches → `glitch_count` holds at 3. Assert `glitch_clr` in the same cycle as a further glitch → `glitch_count`=0.
- **Variants.**
  - `INVERT`=1, `DEBOUNCE`=1, `SYNC_STAGES`=3: `din` 1→0 produces `rise` and `dout`=1 on E3. No glitch is ever counted.
  - Reset mid-QUALIFY (pulse `rst_n` at cycle 8 of 16) → no strobe; qualification restarts after release.
